pps_local_gen: RTL and testbench
================================

# pps_local_gen

Disciplined local 1PPS generator: counts CLK_SYS cycles to produce the `_1PPS_Local` pulse train that the phase-measurement block compares against GPS 1PPS. The loop controller steers the generator with signed per-second period corrections through a valid/ready handshake. A coarse-sync request snaps the local second onto the next GPS edge.

## Interface
- `CLK_FREQ`, 10_000_000: nominal CLK_SYS cycles per second.
- `PULSE_WIDTH`, 1_000_000: cycles `_1PPS_Local` stays high.
- `MAX_ADJ`, 1_000_000: clamp magnitude for corrections. Must satisfy `MAX_ADJ < CLK_FREQ - PULSE_WIDTH`.
- `CNT_W`, 25: counter/period width. Must hold `CLK_FREQ + MAX_ADJ`.
- `CLK_SYS` in 1: system clock. This is the only clock.
- `CLK_RST` in 1: asynchronous, active-low reset.
- `flag_GPS_posedge` in 1: one-cycle GPS rising-edge strobe, already synchronized to CLK_SYS.
- `Sync_Req` in 1: one-cycle pulse that arms coarse sync.
- `Adj_Data` in 24: signed period correction, in cycles.
- `Adj_Valid` in 1: correction offered.
- `Adj_Ready` out 1: correction slot empty.
- `_1PPS_Local` out 1: registered local 1PPS.
- `Sec_Tick` out 1: one-cycle pulse coincident with the `_1PPS_Local` rising edge.
- `Sync_Armed` out 1: coarse sync pending.

## Operation
- `Cnt` counts 0..`Period`-1. In the cycle where `Cnt == Period-1` (the "wrap" cycle), the following happens on the next edge:
  - `Cnt` returns to 0.
  - `Period` loads `CLK_FREQ + clamp(Adj_Pend)` if a correction is pending, otherwise `CLK_FREQ`.
  - The pending slot clears.
- `clamp(x)`: saturate the signed value to [-`MAX_ADJ`, +`MAX_ADJ`]. Sign-extend before adding to `CLK_FREQ`; the arithmetic is done at `CNT_W`+1 bits.
- Correction handshake:
  - `Adj_Ready = ~pend`.
  - A transfer occurs when `Adj_Valid & Adj_Ready`. It captures `Adj_Data` and sets `pend`.
  - A correction applies to exactly one second and is then discarded.
- Capture on the wrap edge: the newly captured value stays pending for the *next* wrap. It never affects the period starting on that edge.
- Coarse sync is a two-state FSM, RUN and ARMED:
  - RUN -> ARMED on `Sync_Req`.
  - ARMED -> RUN on `flag_GPS_posedge`. On that edge, `Cnt` is loaded with 0, `Period` with `CLK_FREQ`, and `pend` is cleared.
  - `Sync_Req` while ARMED has no effect.
  - `flag_GPS_posedge` while in RUN is ignored.
- Priority within one cycle:
  1. Sync edge.
  2. Wrap.
  3. Handshake capture.
- If a sync edge and an `Adj_Valid` transfer coincide, the capture is dropped. `Adj_Ready` is forced low while `flag_GPS_posedge & Sync_Armed`.
- `_1PPS_Local` is registered from `Cnt < PULSE_WIDTH`. `Sec_Tick` is registered from `Cnt == 0`.

## Timing
- Reset values:
  - `Cnt` = 0, `Period` = `CLK_FREQ`, `pend` = 0.
  - `_1PPS_Local` = 0, `Sec_Tick` = 0.
  - `Adj_Ready` = 1.
  - `Sync_Armed` = 1 with `PPS_GEN_AUTOSYNC_EN` defined, otherwise 0.
- First clock after reset release: `_1PPS_Local` = 1 and `Sec_Tick` = 1 (free-run mode).
- Output latency is 1 cycle from the `Cnt` value.
- Sync latency:
  - GPS strobe at edge N loads `Cnt` = 0.
  - Edge N+1 raises `_1PPS_Local` and `Sec_Tick`.
  - `Sync_Armed` falls at edge N.
- Rising-edge spacing equals the loaded `Period`, exactly.
- Reset asserted mid-second: all state returns to reset values immediately (asynchronous). The pending correction is lost.

## Configuration
- `PPS_GEN_AUTOSYNC_EN`:
  - Defined: FSM resets into ARMED. The first GPS edge after reset aligns the local second without a `Sync_Req`.
  - Undefined: FSM resets into RUN and free-runs until `Sync_Req`.

## Structure
- Shared package `gpsdo_pkg` holds:
  - Defaults `CLK_FREQ_DEF` and `PPS_WIDTH_DEF`, also used by the measurement block.
  - `ADJ_W` = 24.
  - The FSM state encoding (RUN = 0, ARMED = 1).
- One sub-module, `adj_clamp`: combinational signed saturation, parameterized by `MAX_ADJ`. Everything else stays in a flat module.

## Test plan
All scenarios use `CLK_FREQ`=100, `PULSE_WIDTH`=10, `MAX_ADJ`=20, `CNT_W`=8, and `PPS_GEN_AUTOSYNC_EN` undefined unless stated.

- **Free-run:** release reset -> `_1PPS_Local` rises at cycles 1, 101, 201; high 10 cycles each; `Sec_Tick` 1-cycle on each rise.
- **Adjust:** transfer `Adj_Data` = +5 mid-second -> next period 105, then 100 again; `Adj_Ready` low until the wrap.
- **Clamp:** `Adj_Data` = -50 -> period 80. `Adj_Data` = 24'h7FFFFF -> period 120.
- **Wrap collision:** transfer +7 on the wrap edge -> the period just starting is 100; the following one is 107.
- **Coarse sync:** `Sync_Req` at cycle 30, GPS strobe at cycle 57 with +9 pending -> `_1PPS_Local` rises at 58, 158; pending discarded; `Sync_Armed` high 31..57.
- **Autosync + reset:**
  - With `PPS_GEN_AUTOSYNC_EN`: `Sync_Armed` = 1 after reset; GPS strobe at 40 -> rise at 41.
  - Assert `CLK_RST` at cycle 70 -> outputs 0 asynchronously; `Sync_Armed` returns to 1.

Source files
------------

// File: rtl/gpsdo_pkg.sv
// gpsdo_pkg: shared GPSDO defaults, correction width and coarse-sync state encoding
package gpsdo_pkg;
  localparam int CLK_FREQ_DEF = 10_000_000;
  localparam int PPS_WIDTH_DEF = 1_000_000;
  localparam int ADJ_W = 24;
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;
endpackage

// File: rtl/adj_clamp.sv
// adj_clamp: combinational signed saturation of a period correction to +/-MAX_ADJ
// Ports: adj_i raw signed correction, adj_o saturated value resized (sign-extended or narrowed) to OUT_W.
module adj_clamp
  import gpsdo_pkg::*;
#(
  parameter int IN_W = ADJ_W,
  parameter int OUT_W = 26,
  parameter int MAX_ADJ = 1_000_000
) (
  input  logic signed [IN_W-1:0]  adj_i,
  output logic signed [OUT_W-1:0] adj_o
);
  localparam logic signed [IN_W-1:0] HI = IN_W'(MAX_ADJ);
  localparam logic signed [IN_W-1:0] LO = -HI;
  logic signed [IN_W-1:0] sat;
  always_comb begin
    sat = adj_i > HI ? HI : adj_i < LO ? LO : adj_i;
    adj_o = OUT_W'(sat);
  end
endmodule

// File: rtl/pps_local_gen.sv
// pps_local_gen: disciplined local 1PPS generator steered by per-second period corrections
// Build option PPS_GEN_AUTOSYNC_EN: coarse sync comes out of reset already armed.
// Ports: CLK_SYS clock, CLK_RST async active-low reset; flag_GPS_posedge GPS edge strobe,
// Sync_Req arms coarse sync; Adj_Data/Adj_Valid/Adj_Ready correction handshake;
// _1PPS_Local local pulse, Sec_Tick one-cycle tick on its rise, Sync_Armed coarse sync pending.
module pps_local_gen
  import gpsdo_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int PULSE_WIDTH = PPS_WIDTH_DEF,
  parameter int MAX_ADJ = 1_000_000,
  parameter int CNT_W = 25
) (
  input  logic                    CLK_SYS,
  input  logic                    CLK_RST,
  input  logic                    flag_GPS_posedge,
  input  logic                    Sync_Req,
  input  logic signed [ADJ_W-1:0] Adj_Data,
  input  logic                    Adj_Valid,
  output logic                    Adj_Ready,
  output logic                    _1PPS_Local,
  output logic                    Sec_Tick,
  output logic                    Sync_Armed
);
  localparam logic [CNT_W-1:0] FREQ = CNT_W'(CLK_FREQ);
  localparam logic [CNT_W-1:0] PW = CNT_W'(PULSE_WIDTH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
`ifdef PPS_GEN_AUTOSYNC_EN
  localparam logic [0:0] ST_RST = ST_ARMED;
`else
  localparam logic [0:0] ST_RST = ST_RUN;
`endif
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic signed [ADJ_W-1:0] adj_q, adj_d;
  logic signed [CNT_W:0] adj_c;
  logic [0:0] state_q, state_d;
  logic pend_q, pend_d, pps_q, pps_d, tick_q, tick_d;
  logic sync_edge, wrap, xfer;
  adj_clamp #(.IN_W(ADJ_W), .OUT_W(CNT_W + 1), .MAX_ADJ(MAX_ADJ)) u_clamp (
    .adj_i(adj_q),
    .adj_o(adj_c)
  );
  always_comb begin
    sync_edge = (state_q == ST_ARMED) & flag_GPS_posedge;
    wrap = cnt_q == period_q - ONE;
    // a capture coinciding with the sync edge would be wiped anyway, so refuse it
    Adj_Ready = ~pend_q & ~sync_edge;
    xfer = Adj_Valid & Adj_Ready;
    state_d = sync_edge ? ST_RUN : Sync_Req ? ST_ARMED : state_q;
    cnt_d = (sync_edge | wrap) ? '0 : cnt_q + ONE;
    // sum at CNT_W+1 bits with the signed correction; result always fits CNT_W
    period_d = sync_edge ? FREQ : wrap ? (pend_q ? CNT_W'({1'b0, FREQ} + adj_c) : FREQ) : period_q;
    // a value captured on the wrap edge waits for the following wrap
    pend_d = sync_edge ? 1'b0 : wrap ? xfer : pend_q | xfer;
    adj_d = xfer ? Adj_Data : adj_q;
    pps_d = cnt_q < PW;
    tick_d = cnt_q == '0;
  end
  always_ff @(posedge CLK_SYS or negedge CLK_RST)
    if (!CLK_RST) begin
      cnt_q <= '0;
      period_q <= FREQ;
      adj_q <= '0;
      pend_q <= 1'b0;
      state_q <= ST_RST;
      pps_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      period_q <= period_d;
      adj_q <= adj_d;
      pend_q <= pend_d;
      state_q <= state_d;
      pps_q <= pps_d;
      tick_q <= tick_d;
    end
  assign _1PPS_Local = pps_q;
  assign Sec_Tick = tick_q;
  assign Sync_Armed = state_q;
endmodule

// File: tb/tb_pps_local_gen.sv
// tb_pps_local_gen: scoreboard bench for pps_local_gen against an absolute-time second-boundary model
module tb_pps_local_gen;
  localparam int FREQ = 100;
  localparam int PW = 10;
  localparam int MAXA = 20;
`ifdef PPS_GEN_AUTOSYNC_EN
  localparam bit ARM_RST = 1'b1;
`else
  localparam bit ARM_RST = 1'b0;
`endif
  typedef struct packed {logic pps; logic tick; logic armed; logic ready;} rec_t;
  logic clk = 1'b0, rst_n = 1'b0, gps = 1'b0, sreq = 1'b0, avalid = 1'b0;
  logic [23:0] adata = '0;
  logic aready, pps, tick, armed;
  rec_t exp_q[$];
  int k, n_pass, n_chk;
  int m_s, m_ps, m_nxt, m_pv;
  bit m_pend, m_armed;
  always #5 clk = ~clk;
  pps_local_gen #(.CLK_FREQ(FREQ), .PULSE_WIDTH(PW), .MAX_ADJ(MAXA), .CNT_W(8)) dut (
    .CLK_SYS(clk),
    .CLK_RST(rst_n),
    .flag_GPS_posedge(gps),
    .Sync_Req(sreq),
    .Adj_Data(adata),
    .Adj_Valid(avalid),
    .Adj_Ready(aready),
    ._1PPS_Local(pps),
    .Sec_Tick(tick),
    .Sync_Armed(armed)
  );
  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %b, expected %b", nm, k, act, exp);
  endtask
  function automatic int clampf(input int v);
    return v > MAXA ? MAXA : v < -MAXA ? -MAXA : v;
  endfunction
  task automatic model_reset();
    m_s = 0;
    m_ps = 0;
    m_nxt = FREQ;
    m_pend = 0;
    m_pv = 0;
    m_armed = ARM_RST;
    k = 0;
  endtask
  // called just after edge k: records expected outputs now visible, then advances the model over edge k+1
  task automatic step(input logic g, input logic sr, input logic v, input logic [23:0] d);
    rec_t r;
    int e;
    bit sync, xfer;
    gps = g;
    sreq = sr;
    avalid = v;
    adata = d;
    r.pps = k > 0 && (k - 1 - m_ps) < PW;
    r.tick = k > 0 && (k - 1) == m_ps;
    r.armed = m_armed;
    r.ready = !m_pend && !(m_armed && g);
    exp_q.push_back(r);
    e = k + 1;
    sync = m_armed && g;
    xfer = v && !m_pend && !sync;
    m_ps = m_s;
    if (sync) begin
      m_s = e;
      m_nxt = e + FREQ;
      m_pend = 0;
      m_armed = 0;
    end else begin
      if (e == m_nxt) begin
        m_s = e;
        m_nxt = e + FREQ + (m_pend ? clampf(m_pv) : 0);
        m_pend = 0;
      end
      if (xfer) begin
        m_pend = 1;
        m_pv = $signed(d);
      end
      if (sr) m_armed = 1;
    end
    @(posedge clk);
    #1;
    k++;
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 24'd0);
  endtask
  task automatic rnd_step();
    logic [23:0] d;
    d = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 80)) - 24'd40;
    step($urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 19) == 0, d);
  endtask
  initial begin : mon
    rec_t r;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        chk("pps", pps, r.pps);
        chk("sec_tick", tick, r.tick);
        chk("sync_armed", armed, r.armed);
        chk("adj_ready", aready, r.ready);
      end
    end
  end
  initial begin
    model_reset();
    #2;
    chk("rst_pps", pps, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_ready", aready, 1'b1);
    chk("rst_armed", armed, ARM_RST);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (130) idle();
    step(1'b0, 1'b0, 1'b1, 24'd5);
    repeat (190) idle();
    step(1'b0, 1'b0, 1'b1, -24'sd50);
    repeat (100) idle();
    step(1'b0, 1'b0, 1'b1, 24'h7FFFFF);
    for (int i = 0; i < 300 && (m_pend || m_nxt != k + 1); i++) idle();
    step(1'b0, 1'b0, 1'b1, 24'd7);
    repeat (30) idle();
    step(1'b0, 1'b1, 1'b0, 24'd0);
    repeat (20) idle();
    step(1'b0, 1'b0, 1'b1, 24'd9);
    repeat (6) idle();
    step(1'b1, 1'b0, 1'b0, 24'd0);
    repeat (150) idle();
    repeat (3000) rnd_step();
    for (int i = 0; i < 300 && m_pend; i++) idle();
    step(1'b0, 1'b0, 1'b1, 24'd3);
    repeat (40) idle();
    gps = 1'b0;
    sreq = 1'b0;
    avalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pps", pps, 1'b0);
    chk("async_rst_tick", tick, 1'b0);
    chk("async_rst_ready", aready, 1'b1);
    chk("async_rst_armed", armed, ARM_RST);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (500) rnd_step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
